// File: rtl/rank_pkg.sv
// Shared definitions for the top-K reporter: default widths, report FSM states
// and the rank-entry record.
package rank_pkg;

   localparam int DEF_VAL_W = 24;
   localparam int DEF_ID_W  = 6;
   localparam int DEF_K     = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      FIN  = 2'd2
   } rpt_state_e;

   typedef struct packed {
      logic [DEF_VAL_W-1:0] val;
      logic [DEF_ID_W-1:0]  id;
   } rank_entry_t;

endpackage

// File: rtl/rank_snapshot.sv
// K-entry capture register for the sorted ranking; loaded on one strobe and
// read back one entry at a time by rank index.
module rank_snapshot
   import rank_pkg::*;
#(
   parameter int VAL_W = DEF_VAL_W,
   parameter int ID_W  = DEF_ID_W,
   parameter int K     = DEF_K,
   parameter int IDX_W = $clog2(K)
) (
   input  logic               clk,
   input  logic               load_i,
   input  logic [K*VAL_W-1:0] vals_i,
   input  logic [K*ID_W-1:0]  ids_i,
   input  logic [IDX_W-1:0]   rd_idx_i,
   output logic [VAL_W-1:0]   rd_val_o,
   output logic [ID_W-1:0]    rd_id_o
);

   logic [VAL_W-1:0] val_q [K];
   logic [ID_W-1:0]  id_q  [K];

   // NOTE: the entries carry no reset; they are only read after a load, and
   // non-blocking assignments keep every entry updating on the same edge.
   always_ff @(posedge clk) begin
      if (load_i) begin
         for (int i = 0; i < K; i++) begin
            val_q[i] <= vals_i[i*VAL_W +: VAL_W];
            id_q[i]  <= ids_i[i*ID_W +: ID_W];
         end
      end
   end

   // NOTE: defaults first so no path through this block can infer a latch.
   always_comb begin
      rd_val_o = '0;
      rd_id_o  = '0;
      for (int i = 0; i < K; i++) begin
         if (rd_idx_i == IDX_W'(i)) begin
            rd_val_o = val_q[i];
            rd_id_o  = id_q[i];
         end
      end
   end

endmodule

// File: rtl/top10_reporter.sv
// Streams a captured top-K ranking as K valid/ready beats after sort_done rises.
// Define TOP10_ORDER_CHECK_EN to add the sticky order_err descending-order monitor.
module top10_reporter
   import rank_pkg::*;
#(
   parameter int VAL_W = DEF_VAL_W,
   parameter int ID_W  = DEF_ID_W,
   parameter int K     = DEF_K
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sort_done,
   input  logic [K*VAL_W-1:0]   top_vals,
   input  logic [K*ID_W-1:0]    top_ids,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [$clog2(K)-1:0] out_rank,
   output logic [VAL_W-1:0]     out_val,
   output logic [ID_W-1:0]      out_id,
   output logic                 out_last,
   output logic                 busy,
   output logic                 report_done
`ifdef TOP10_ORDER_CHECK_EN
   ,
   output logic                 order_err
`endif
);

   localparam int                RANK_W    = $clog2(K);
   localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(K - 1);

   rpt_state_e        state_q, state_d;
   logic              done_q;
   logic [RANK_W-1:0] rank_q, rank_d;
   logic              start;
   logic              hs;
   logic              load;
   logic [VAL_W-1:0]  snap_val;
   logic [ID_W-1:0]   snap_id;

   assign start = sort_done & ~done_q;
   assign hs    = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         rank_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= sort_done;
         rank_q  <= rank_d;
      end
   end

   // Start edges seen outside IDLE are dropped; done_q still tracks the level
   // so a held-high sort_done cannot retrigger once the FSM returns to IDLE.
   always_comb begin
      state_d = state_q;
      rank_d  = rank_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SEND;
               rank_d  = '0;
               load    = 1'b1;
            end
         end
         SEND: begin
            if (hs) begin
               if (rank_q == LAST_RANK) begin
                  state_d = FIN;
                  rank_d  = '0;
               end else begin
                  rank_d = rank_q + RANK_W'(1);
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   rank_snapshot #(
      .VAL_W (VAL_W),
      .ID_W  (ID_W),
      .K     (K),
      .IDX_W (RANK_W)
   ) u_snapshot (
      .clk      (clk),
      .load_i   (load),
      .vals_i   (top_vals),
      .ids_i    (top_ids),
      .rd_idx_i (rank_q),
      .rd_val_o (snap_val),
      .rd_id_o  (snap_id)
   );

   // Beat fields are gated so the bus reads all-zero whenever no beat is offered.
   assign out_valid   = (state_q == SEND);
   assign busy        = out_valid;
   assign report_done = (state_q == FIN);
   assign out_rank    = out_valid ? rank_q : '0;
   assign out_val     = out_valid ? snap_val : '0;
   assign out_id      = out_valid ? snap_id : '0;
   assign out_last    = out_valid & (rank_q == LAST_RANK);

`ifdef TOP10_ORDER_CHECK_EN
   logic [VAL_W-1:0] prev_val_q;
   logic             order_err_q;

   // Rank 0 only seeds the comparison; equal neighbours are a legal ranking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_val_q  <= '0;
         order_err_q <= 1'b0;
      end else if (hs) begin
         if ((rank_q != '0) && (out_val > prev_val_q)) begin
            order_err_q <= 1'b1;
         end
         prev_val_q <= out_val;
      end
   end

   assign order_err = order_err_q;
`endif

endmodule

// File: tb/tb_top10_reporter.sv
// Randomised and directed bench for top10_reporter against a beat-queue model.
// Define TOP10_ORDER_CHECK_EN to also check the order_err monitor.
`timescale 1ns/1ps
module tb_top10_reporter;
   import rank_pkg::*;

   localparam int VAL_W  = DEF_VAL_W;
   localparam int ID_W   = DEF_ID_W;
   localparam int K      = DEF_K;
   localparam int RANK_W = $clog2(K);

   logic               clk = 1'b0;
   logic               reset;
   logic               sort_done;
   logic [K*VAL_W-1:0] top_vals;
   logic [K*ID_W-1:0]  top_ids;
   logic               out_ready;
   logic               out_valid;
   logic [RANK_W-1:0]  out_rank;
   logic [VAL_W-1:0]   out_val;
   logic [ID_W-1:0]    out_id;
   logic               out_last;
   logic               busy;
   logic               report_done;
`ifdef TOP10_ORDER_CHECK_EN
   logic               order_err;
`endif

   int checks   = 0;
   int failures = 0;
   int rd_count = 0;

   always #5 clk = ~clk;

   top10_reporter #(
      .VAL_W (VAL_W),
      .ID_W  (ID_W),
      .K     (K)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sort_done   (sort_done),
      .top_vals    (top_vals),
      .top_ids     (top_ids),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_rank    (out_rank),
      .out_val     (out_val),
      .out_id      (out_id),
      .out_last    (out_last),
      .busy        (busy),
      .report_done (report_done)
`ifdef TOP10_ORDER_CHECK_EN
      ,
      .order_err   (order_err)
`endif
   );

   // Reference model: a queue of beats still owed to the consumer.
   rank_entry_t      exp_q[$];
   bit               m_prev_sd;
   bit               m_done;
   bit               m_err;
   logic [VAL_W-1:0] m_last_val;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic void model_reset();
      exp_q.delete();
      m_prev_sd  = 1'b0;
      m_done     = 1'b0;
      m_err      = 1'b0;
      m_last_val = '0;
   endfunction

   function automatic int front_rank();
      return (exp_q.size() == 0) ? -1 : K - exp_q.size();
   endfunction

   // Applies one rising edge to the model using the inputs held across it.
   function automatic void model_edge();
      bit in_send, in_fin, start, new_done;
      int rank;
      if (reset) begin
         model_reset();
         return;
      end
      in_send  = exp_q.size() != 0;
      in_fin   = m_done;
      start    = !in_send && !in_fin && sort_done && !m_prev_sd;
      new_done = 1'b0;
      if (in_send && out_ready) begin
         rank = front_rank();
         if (rank >= 1 && exp_q[0].val > m_last_val) m_err = 1'b1;
         m_last_val = exp_q[0].val;
         void'(exp_q.pop_front());
         new_done = (exp_q.size() == 0);
      end
      if (start) begin
         for (int i = 0; i < K; i++) begin
            exp_q.push_back('{val: top_vals[i*VAL_W +: VAL_W], id: top_ids[i*ID_W +: ID_W]});
         end
      end
      m_done    = new_done;
      m_prev_sd = sort_done;
   endfunction

   task automatic check_outputs();
      logic [63:0] got_beat, exp_beat;
      int rank;
      got_beat = 64'({out_rank, out_val, out_id, out_last});
      if (exp_q.size() != 0) begin
         rank     = front_rank();
         exp_beat = 64'({RANK_W'(rank), exp_q[0].val, exp_q[0].id, rank == K - 1});
      end else begin
         exp_beat = '0;
      end
      check("out_valid", out_valid, exp_q.size() != 0);
      check("busy", busy, exp_q.size() != 0);
      check("report_done", report_done, m_done);
      check("beat", got_beat, exp_beat);
`ifdef TOP10_ORDER_CHECK_EN
      check("order_err", order_err, m_err);
`endif
      if (report_done) rd_count++;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic set_desc(input int base, input int step);
      for (int i = 0; i < K; i++) begin
         top_vals[i*VAL_W +: VAL_W] = VAL_W'(base - step * i);
         top_ids[i*ID_W +: ID_W]    = ID_W'(i);
      end
   endtask

   task automatic rearm();
      sort_done = 1'b0;
      cycle();
      sort_done = 1'b1;
   endtask

   initial begin
      int  held4;
      int  stalls;
      bit  hit;

      reset     = 1'b1;
      sort_done = 1'b0;
      out_ready = 1'b0;
      top_vals  = '0;
      top_ids   = '0;
      model_reset();
      run(3);
      check("reset_valid", out_valid, 1'b0);
      reset = 1'b0;
      run(2);

      // Plain descending report with an always-ready consumer.
      set_desc(1000, 100);
      out_ready = 1'b1;
      sort_done = 1'b1;
      rd_count  = 0;
      cycle();
      check("first_val", out_val, 1000);
      check("first_rank", out_rank, 0);
      run(13);
      check("desc_reports", rd_count, 1);

      // Three-cycle stall on rank 4.
      rearm();
      held4  = 0;
      stalls = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (out_valid && out_rank == 4) held4++;
         if (front_rank() == 4 && stalls < 3) begin
            out_ready = 1'b0;
            stalls++;
         end else begin
            out_ready = 1'b1;
         end
      end
      check("rank4_hold", held4, 4);

      // Inputs overwritten mid-report must not leak into the beats.
      rearm();
      for (int i = 0; i < 16; i++) begin
         cycle();
         if (front_rank() == 2) top_vals = '1;
      end
      set_desc(1000, 100);

      // Held-high sort_done produces one report; a one-cycle low re-arms it.
      rearm();
      rd_count = 0;
      run(32);
      check("retrig_once", rd_count, 1);
      rearm();
      run(14);
      check("retrig_twice", rd_count, 2);

      // Asynchronous reset in the middle of rank 6, sort_done left high.
      rearm();
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         cycle();
         if (out_valid && out_rank == 6) hit = 1'b1;
      end
      check("reach_rank6", hit, 1'b1);
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_beat", 64'({out_rank, out_val, out_id, out_last}), 64'd0);
      check_outputs();
      run(2);
      reset    = 1'b0;
      rd_count = 0;
      cycle();
      check("post_rst_rank", out_rank, 0);
      check("post_rst_val", out_val, 1000);
      run(12);
      check("post_rst_report", rd_count, 1);

      // Out-of-order ranking: 500,400,450,... then a fresh non-strict one.
      set_desc(500, 50);
      top_vals[1*VAL_W +: VAL_W] = VAL_W'(400);
      top_vals[2*VAL_W +: VAL_W] = VAL_W'(450);
      rearm();
      run(16);
      reset = 1'b1;
      model_reset();
      cycle();
      sort_done = 1'b0;
      reset     = 1'b0;
      set_desc(300, 20);
      top_vals[1*VAL_W +: VAL_W] = VAL_W'(300);
      cycle();
      sort_done = 1'b1;
      run(16);

      // Random traffic: toggling sort_done, churning inputs, random backpressure.
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 7) == 0) sort_done = ~sort_done;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            for (int j = 0; j < K; j++) begin
               top_vals[j*VAL_W +: VAL_W] = VAL_W'($urandom);
               top_ids[j*ID_W +: ID_W]    = ID_W'($urandom);
            end
         end
         cycle();
      end
      out_ready = 1'b1;
      run(15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
